// File: rtl/and_gate_behaviour_timing.sv
// Bitwise AND of two operands delivered through a fixed-depth register pipeline.
// The result is sampled on each rising edge and appears on s LATENCY-1 edges
// later, so LATENCY=1 updates s on the sampling edge itself. s is driven only
// by the last pipeline register and has no combinational path from a or b.
module and_gate_behaviour_timing #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s
);

  // Reject parameter values the pipeline is not built for
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("and_gate_behaviour_timing: WIDTH must be in 1..64");
  end
  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("and_gate_behaviour_timing: LATENCY must be in 1..8");
  end

  logic [WIDTH-1:0] pipe [LATENCY];

  // First stage samples a & b; reset clears it and discards the inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe[0] <= '0;
    end else begin
      pipe[0] <= a & b;
    end
  end

  // Remaining stages shift one place per edge; reset flushes every stage
  for (genvar i = 1; i < int'(LATENCY); i++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst) begin
        pipe[i] <= '0;
      end else begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign s = pipe[LATENCY-1];

endmodule

// File: tb/tb_and_gate_behaviour_timing.sv
// Directed bench for and_gate_behaviour_timing: a 1-bit single-stage instance
// and a 4-bit three-stage instance share one 20 ns clock.
`timescale 1ns/1ps
module tb_and_gate_behaviour_timing;

  logic       clk;
  logic       rst1, rst3;
  logic       a1, b1, s1;
  logic [3:0] a3, b3, s3;

  int checks;
  int failures;

  and_gate_behaviour_timing #(.WIDTH(1), .LATENCY(1)) u_w1 (
    .clk(clk), .rst(rst1), .a(a1), .b(b1), .s(s1)
  );

  and_gate_behaviour_timing #(.WIDTH(4), .LATENCY(3)) u_w4 (
    .clk(clk), .rst(rst3), .a(a3), .b(b3), .s(s3)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst3 = 1'b1;
    a1 = 1'b1; b1 = 1'b1;
    a3 = 4'hF; b3 = 4'hF;
    step();
    checks++;
    if (s1 !== 1'b0) begin
      failures++; $display("FAIL reset_s1 got=%b want=0", s1);
    end
    checks++;
    if (s3 !== 4'h0) begin
      failures++; $display("FAIL reset_s3 got=%h want=0", s3);
    end
    a1 = 1'b0; b1 = 1'b0; a3 = 4'h0; b3 = 4'h0;
    step();
    rst1 = 1'b0; rst3 = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [1:0] vec [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic       exp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      a1 = vec[i][1]; b1 = vec[i][0];
      step();
      checks++;
      if (s1 !== exp[i]) begin
        failures++; $display("FAIL truth_%0d got=%b want=%b", i, s1, exp[i]);
      end
    end
  endtask

  task automatic test_glitch();
    a1 = 1'b1; b1 = 1'b0;
    step();
    checks++;
    if (s1 !== 1'b0) begin
      failures++; $display("FAIL glitch_pre got=%b want=0", s1);
    end
    #4 b1 = 1'b1;
    #3;
    checks++;
    if (s1 !== 1'b0) begin
      failures++; $display("FAIL glitch_mid got=%b want=0", s1);
    end
    #2 b1 = 1'b0;
    step();
    checks++;
    if (s1 !== 1'b0) begin
      failures++; $display("FAIL glitch_edge got=%b want=0", s1);
    end
  endtask

  task automatic test_hold();
    a1 = 1'b1; b1 = 1'b1;
    step();
    checks++;
    if (s1 !== 1'b1) begin
      failures++; $display("FAIL hold_edge got=%b want=1", s1);
    end
    #8 a1 = 1'b0;
    #2;
    checks++;
    if (s1 !== 1'b1) begin
      failures++; $display("FAIL hold_mid got=%b want=1", s1);
    end
    step();
    checks++;
    if (s1 !== 1'b0) begin
      failures++; $display("FAIL hold_next got=%b want=0", s1);
    end
  endtask

  task automatic test_sync_reset();
    a1 = 1'b1; b1 = 1'b1;
    step();
    checks++;
    if (s1 !== 1'b1) begin
      failures++; $display("FAIL rst_pre got=%b want=1", s1);
    end
    // Reset pulse that never overlaps an edge must be ignored
    #3 rst1 = 1'b1;
    #3;
    checks++;
    if (s1 !== 1'b1) begin
      failures++; $display("FAIL rst_between got=%b want=1", s1);
    end
    rst1 = 1'b0;
    step();
    checks++;
    if (s1 !== 1'b1) begin
      failures++; $display("FAIL rst_between_edge got=%b want=1", s1);
    end
    rst1 = 1'b1;
    step();
    checks++;
    if (s1 !== 1'b0) begin
      failures++; $display("FAIL rst_edge got=%b want=0", s1);
    end
    rst1 = 1'b0;
    step();
    checks++;
    if (s1 !== 1'b1) begin
      failures++; $display("FAIL rst_release got=%b want=1", s1);
    end
  endtask

  task automatic test_latency();
    logic [3:0] exp [4] = '{4'h0, 4'h0, 4'hA, 4'h0};
    a3 = 4'hF; b3 = 4'hA;
    for (int i = 0; i < 4; i++) begin
      step();
      a3 = 4'h0; b3 = 4'h0;
      checks++;
      if (s3 !== exp[i]) begin
        failures++; $display("FAIL latency_n%0d got=%h want=%h", i, s3, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] va  [7] = '{4'hF, 4'hC, 4'h3, 4'h9, 4'h0, 4'h0, 4'h0};
    logic [3:0] vb  [7] = '{4'hA, 4'h6, 4'h5, 4'hF, 4'h0, 4'h0, 4'h0};
    logic [3:0] exp [7] = '{4'h0, 4'h0, 4'hA, 4'h4, 4'h1, 4'h9, 4'h0};
    for (int i = 0; i < 7; i++) begin
      a3 = va[i]; b3 = vb[i];
      step();
      checks++;
      if (s3 !== exp[i]) begin
        failures++; $display("FAIL b2b_%0d got=%h want=%h", i, s3, exp[i]);
      end
    end
  endtask

  task automatic test_flush();
    logic [3:0] va [3] = '{4'hF, 4'hF, 4'h7};
    logic [3:0] vb [3] = '{4'hF, 4'h7, 4'h3};
    logic [3:0] exp_post [3] = '{4'h0, 4'h0, 4'h5};
    for (int i = 0; i < 3; i++) begin
      a3 = va[i]; b3 = vb[i];
      step();
    end
    checks++;
    if (s3 !== 4'hF) begin
      failures++; $display("FAIL flush_fill got=%h want=f", s3);
    end
    a3 = 4'hF; b3 = 4'hF; rst3 = 1'b1;
    step();
    checks++;
    if (s3 !== 4'h0) begin
      failures++; $display("FAIL flush_rst got=%h want=0", s3);
    end
    rst3 = 1'b0; a3 = 4'h5; b3 = 4'hD;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (s3 !== exp_post[i]) begin
        failures++; $display("FAIL flush_post_%0d got=%h want=%h", i, s3, exp_post[i]);
      end
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst1 = 1'b1; rst3 = 1'b1;
    a1 = 1'b0; b1 = 1'b0; a3 = 4'h0; b3 = 4'h0;
    #5;
    test_reset();
    test_truth_table();
    test_glitch();
    test_hold();
    test_sync_reset();
    test_latency();
    test_back_to_back();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
